// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART blocks.
//   - parity mode encodings used by the PARITY parameter
//   - receiver state encoding
//   - constant functions for the clock divider and counter widths
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest, never below 1.
    function automatic int calc_div(input int clock_rate, input int baud_rate,
                                    input int oversample);
        int denom;
        int div;
        denom = baud_rate * oversample;
        div   = (clock_rate + denom / 2) / denom;
        return (div < 1) ? 1 : div;
    endfunction

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int calc_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator shared by the UART receiver and transmitter.
// Emits a one-clock tick every DIV clocks and reports which tick of the
// bit it is (0..OVERSAMPLE-1). A restart re-phases both counters so the
// first tick lands DIV clocks later carrying index 1; index MID then sits
// half a bit after the restart and index 0 marks the bit boundary.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   restart   in   re-align the tick phase to this clock
//   tick      out  one-clock oversample tick
//   tick_idx  out  index of the current tick within the bit
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int DIV        = 78,
    parameter int OVERSAMPLE = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                restart,
    output logic                                tick,
    output logic [calc_width(OVERSAMPLE)-1:0]   tick_idx
);

    localparam int DIV_W = calc_width(DIV);
    localparam int IDX_W = calc_width(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0] div_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            tick     <= 1'b0;
            tick_idx <= '0;
        end else if (restart) begin
            div_cnt  <= '0;
            tick     <= 1'b0;
            tick_idx <= '0;
        end else begin
            tick <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                div_cnt  <= '0;
                tick_idx <= (tick_idx == IDX_LAST) ? '0 : tick_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting, false-start
// rejection, optional parity, one or two stop bits and separate error flags.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   rxEn         in   receive enable; dropping it aborts a frame
//   rxIn         in   raw serial line, idle high, asynchronous
//   rxBusy       out  high from accepted start edge to end of frame
//   rxDone       out  one-clock pulse per completed frame
//   rxErr        out  one-clock pulse with rxDone when the frame had an error
//   rxFrameErr   out  stop bit low in last frame, held until next rxDone
//   rxParityErr  out  parity mismatch in last frame, held until next rxDone
//   rxOut        out  last payload, held until next rxDone
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxEn,
    input  logic                 rxIn,
    output logic                 rxBusy,
    output logic                 rxDone,
    output logic                 rxErr,
    output logic                 rxFrameErr,
    output logic                 rxParityErr,
    output logic [DATA_BITS-1:0] rxOut
);

    localparam int DIV   = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam int IDX_W = calc_width(OVERSAMPLE);
    localparam int CNT_W = calc_width(DATA_BITS);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [IDX_W-1:0] SAMPLE_A  = IDX_W'(MID - 1);
    localparam logic [IDX_W-1:0] SAMPLE_B  = IDX_W'(MID);
    localparam logic [IDX_W-1:0] SAMPLE_C  = IDX_W'(MID + 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);

    rx_state_t state, state_next;

    logic sync1, sync2, sync_prev;
    logic falling;
    logic tick;
    logic [IDX_W-1:0] tick_idx;
    logic samp_a, samp_b;
    logic vote, vote_tick;
    logic [CNT_W-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic frame_err_pend, parity_err_pend;
    logic frame_err_now, parity_bad;
    logic need_high;

    logic restart, shift_en, bit_clr, bit_inc, parity_chk, stop_chk, finish;

    uart_baud_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .tick     (tick),
        .tick_idx (tick_idx)
    );

    assign falling   = sync_prev & ~sync2;
    assign vote_tick = tick && (tick_idx == SAMPLE_C);
    // Third sample is the live synchronised value on the MID+1 tick.
    assign vote      = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);
    // Odd parity wants data^parity == 1, even wants 0.
    assign parity_bad    = (^shift_reg ^ vote) ^ (PARITY == PARITY_ODD);
    assign frame_err_now = frame_err_pend | (stop_chk & ~vote);
    assign rxBusy        = (state != RX_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RX_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        shift_en   = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        parity_chk = 1'b0;
        stop_chk   = 1'b0;
        finish     = 1'b0;
        if (!rxEn) begin
            state_next = RX_IDLE;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (falling && !need_high) begin
                        state_next = RX_START;
                        restart    = 1'b1;
                    end
                end
                RX_START: begin
                    if (vote_tick) begin
                        if (vote) begin
                            state_next = RX_IDLE;
                        end else begin
                            state_next = RX_DATA;
                            bit_clr    = 1'b1;
                        end
                    end
                end
                RX_DATA: begin
                    if (vote_tick) begin
                        shift_en = 1'b1;
                        if (bit_cnt == DATA_LAST) begin
                            bit_clr    = 1'b1;
                            state_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (vote_tick) begin
                        parity_chk = 1'b1;
                        state_next = RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (vote_tick) begin
                        stop_chk = 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            finish     = 1'b1;
                            state_next = RX_IDLE;
                        end else begin
                            bit_inc = 1'b1;
                        end
                    end
                end
                default: state_next = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1           <= 1'b1;
            sync2           <= 1'b1;
            sync_prev       <= 1'b1;
            samp_a          <= 1'b1;
            samp_b          <= 1'b1;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            frame_err_pend  <= 1'b0;
            parity_err_pend <= 1'b0;
            need_high       <= 1'b0;
            rxDone          <= 1'b0;
            rxErr           <= 1'b0;
            rxFrameErr      <= 1'b0;
            rxParityErr     <= 1'b0;
            rxOut           <= '0;
        end else begin
            sync1     <= rxIn;
            sync2     <= sync1;
            sync_prev <= sync2;

            if (tick && tick_idx == SAMPLE_A) samp_a <= sync2;
            if (tick && tick_idx == SAMPLE_B) samp_b <= sync2;

            if (bit_clr)      bit_cnt <= '0;
            else if (bit_inc) bit_cnt <= bit_cnt + 1'b1;

            if (shift_en) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};

            if (restart) begin
                frame_err_pend  <= 1'b0;
                parity_err_pend <= 1'b0;
            end else begin
                if (parity_chk && parity_bad) parity_err_pend <= 1'b1;
                if (stop_chk && !vote)        frame_err_pend  <= 1'b1;
            end

            rxDone <= finish;
            rxErr  <= finish & (frame_err_now | parity_err_pend);
            if (finish) begin
                rxOut       <= shift_reg;
                rxFrameErr  <= frame_err_now;
                rxParityErr <= parity_err_pend;
            end

            // After a frame error the line may still be low (break); wait
            // until it has been seen high before accepting another edge.
            if (finish && frame_err_now) need_high <= 1'b1;
            else if (sync2)              need_high <= 1'b0;
        end
    end

endmodule
